// File: rtl/ring_local_port.sv
// ring_local_port: local (NIC) port of a two-VC slotted ring router.
// Each VC owns a 1-entry buffer in each direction. The polarity bit
// alternates the VC roles every cycle: the external VC (e) talks to the
// NIC link, the internal VC (i) talks to the switch. Both sides can act
// in the same cycle without conflict because they always target
// different buffers.
module ring_local_port #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  // NIC-to-router link
  input  logic                  pesi,
  output logic                  peri,
  input  logic [DATA_WIDTH-1:0] pedi,
  // router-to-NIC link
  output logic                  peso,
  input  logic                  pero,
  output logic [DATA_WIDTH-1:0] pedo,
  output logic                  polarity,
  // switch side, receive direction
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_take,
  // switch side, transmit direction
  input  logic                  tx_wr,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  // status
  output logic [15:0]           rx_count,
  output logic [15:0]           tx_count,
  output logic                  vc_err
);

  logic [DATA_WIDTH-1:0] ibuf [2];
  logic [DATA_WIDTH-1:0] obuf [2];
  logic [1:0]            ifull;
  logic [1:0]            ofull;

  logic ext_vc;
  logic int_vc;
  logic link_in_fire;
  logic rx_take_fire;
  logic tx_wr_fire;
  logic link_out_fire;

  // VC role selection: the link uses the VC opposite to the polarity bit,
  // the switch uses the other one.
  always_comb begin
    ext_vc = ~polarity;
    int_vc = polarity;
  end

  // Handshake outputs; all of them are held low while reset is asserted so
  // that no transfer can complete in a reset cycle.
  always_comb begin
    peri     = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    peso     = 1'b0;
    pedo     = '0;
    rx_data  = ibuf[int_vc];
    if (!reset) begin
      peri     = ~ifull[ext_vc];
      rx_valid = ifull[int_vc];
      tx_ready = ~ofull[int_vc];
      peso     = ofull[ext_vc] & pero;
      if (peso) begin
        pedo = obuf[ext_vc];
      end
    end
  end

  // Transfer qualifiers; they inherit the reset gating from the handshakes.
  always_comb begin
    link_in_fire  = pesi & peri;
    rx_take_fire  = rx_take & rx_valid;
    tx_wr_fire    = tx_wr & tx_ready;
    link_out_fire = peso;
  end

  // Polarity alternates every cycle and restarts at 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      polarity <= 1'b0;
    end else begin
      polarity <= ~polarity;
    end
  end

  // Inbound buffer data is captured only on an accepted link transfer; its
  // contents are meaningless while the matching full flag is clear.
  always_ff @(posedge clk) begin
    if (link_in_fire) begin
      ibuf[ext_vc] <= pedi;
    end
  end

  // Inbound full flags: the link fills the external VC, the switch drains
  // the internal VC, never the same entry in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifull <= 2'b00;
    end else begin
      if (link_in_fire) begin
        ifull[ext_vc] <= 1'b1;
      end
      if (rx_take_fire) begin
        ifull[int_vc] <= 1'b0;
      end
    end
  end

  // Outbound buffer data is captured only on an accepted switch write.
  always_ff @(posedge clk) begin
    if (tx_wr_fire) begin
      obuf[int_vc] <= tx_data;
    end
  end

  // Outbound full flags: the switch fills the internal VC, the link drains
  // the external VC whenever the NIC is ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      ofull <= 2'b00;
    end else begin
      if (tx_wr_fire) begin
        ofull[int_vc] <= 1'b1;
      end
      if (link_out_fire) begin
        ofull[ext_vc] <= 1'b0;
      end
    end
  end

  // Link transfer counters, free-running modulo 2^16.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_count <= 16'd0;
      tx_count <= 16'd0;
    end else begin
      if (link_in_fire) begin
        rx_count <= rx_count + 16'd1;
      end
      if (link_out_fire) begin
        tx_count <= tx_count + 16'd1;
      end
    end
  end

  // Sticky flag for packets whose VC bit disagrees with the VC they were
  // stored in; the packet itself is still accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      vc_err <= 1'b0;
    end else if ((link_in_fire && (pedi[0] != ext_vc)) ||
                 (tx_wr_fire && (tx_data[0] != int_vc))) begin
      vc_err <= 1'b1;
    end
  end

endmodule

// File: doc/ring_local_port.md
RING_LOCAL_PORT -- requirements
Module: ring_local_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, packet width; bit 0 of every packet is the VC bit (0 = even, 1 = odd).
REQ-002 SHALL have ports: clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pesi  input  1  send handshake from the NIC (NIC-to-router link).
REQ-005 peri  output  1  ready handshake to the NIC (NIC-to-router link).
REQ-006 pedi  input  DATA_WIDTH  packet data from the NIC.
REQ-007 peso  output  1  send handshake to the NIC (router-to-NIC link).
REQ-008 pero  input  1  ready handshake from the NIC (router-to-NIC link).
REQ-009 pedo  output  DATA_WIDTH  packet data to the NIC.
REQ-010 polarity  output  1  polarity register, also driven to the attached NIC.
REQ-011 rx_valid  output  1  received packet available to the switch.
REQ-012 rx_data  output  DATA_WIDTH  received packet to the switch.
REQ-013 rx_take  input  1  switch consumes rx_data.
REQ-014 tx_wr  input  1  switch writes a packet for the NIC.
REQ-015 tx_data  input  DATA_WIDTH  packet from the switch.
REQ-016 tx_ready  output  1  tx buffer for the current internal VC is free.
REQ-017 rx_count, tx_count  output  16 each  link-transfer counters.
REQ-018 vc_err  output  1  sticky VC-mismatch flag.

Function
REQ-019 The block SHALL hold 1-entry buffers ibuf[0], ibuf[1] (NIC-to-router) and obuf[0], obuf[1] (router-to-NIC), each with a full flag.
REQ-020 polarity SHALL toggle on every clock edge when reset is low.
REQ-021 External VC e = 0 when polarity = 1 and e = 1 when polarity = 0; internal VC i = ~e.
REQ-022 peri SHALL equal ~ifull[e]; when pesi and peri are both high, ibuf[e] <= pedi and ifull[e] <= 1 at the edge.
REQ-023 rx_valid SHALL equal ifull[i] and rx_data SHALL equal ibuf[i]; rx_take with rx_valid high clears ifull[i] at the edge; rx_take with rx_valid low has no effect.
REQ-024 Latency SHALL be one cycle from link accept to rx_valid, because the VC roles swap at that edge.
REQ-025 tx_ready SHALL equal ~ofull[i]; tx_wr with tx_ready high sets obuf[i] <= tx_data and ofull[i] <= 1; tx_wr with tx_ready low is dropped.
REQ-026 peso SHALL equal ofull[e] AND pero.
REQ-027 pedo SHALL equal obuf[e] when peso = 1, and 0 otherwise.
REQ-028 At every edge with peso = 1, ofull[e] SHALL clear.
REQ-029 Link-side and switch-side operations in the same cycle always target different VCs and SHALL both complete.
REQ-030 A full buffer SHALL never be overwritten; its holder is stalled by peri = 0 or tx_ready = 0.
REQ-031 rx_count SHALL increment per accepted pedi transfer, and tx_count per peso transfer; both are modulo 2^16, so 0xFFFF wraps to 0x0000.
REQ-032 vc_err SHALL set and remain set until reset on either of:
- an accepted pedi with pedi[0] != e;
- an accepted tx_data with tx_data[0] != i.
The packet is still stored in both cases.

Reset
REQ-033 While reset is high at an edge, the block SHALL clear all four full flags, set polarity to 0, and clear rx_count, tx_count and vc_err; buffer contents are don't-care.
REQ-034 While reset is high, peri, peso, rx_valid and tx_ready SHALL be forced to 0 and pedo to 0.
REQ-035 Reset asserted mid-transfer SHALL discard all buffered packets, and no handshake completes in that cycle.
REQ-036 The first cycle after reset SHALL have polarity = 0, e = 1, peri = 1 and tx_ready = 1.

Verification
REQ-037 Reset, then pesi = 1 with pedi = 0x...0001 in the first cycle -> peri = 1, accepted; next cycle rx_valid = 1, rx_data = 0x...0001, rx_count = 1.
REQ-038 Accept an odd packet and hold rx_take = 0; offer another odd packet two cycles later -> peri = 0 when e = 1, packet not accepted; assert rx_take -> peri returns to 1 at the next e = 1 cycle.
REQ-039 tx_wr with tx_data = 0x...00A0 when i = 0 and pero = 1 -> next cycle peso = 1, pedo = 0x...00A0, tx_count = 1; pero held 0 -> peso stays 0 and the packet is retained.
REQ-040 pedi[0] = 0 accepted while e = 1 -> vc_err = 1, packet stored in ibuf[1]; vc_err stays 1 until reset.
REQ-041 Preload rx_count = 0xFFFF with 65535 transfers, then one more -> rx_count = 0x0000.
REQ-042 Fill all four buffers, then assert reset -> next cycle all full flags clear, rx_valid = 0, tx_ready = 1, counters 0, polarity 0.
